// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states,
// owner encoding and the legal MEM_LATENCY range.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

  localparam int MEM_LATENCY_MIN = 1;
  localparam int MEM_LATENCY_MAX = 4;
  // Counter holds MEM_LATENCY-1, so 0..3 fits in two bits.
  localparam int CNT_W = 2;

endpackage

// File: rtl/arb_pick.sv
// Winner select between the I-cache and D-cache requesters.
// Fixed D-over-I priority by default; round-robin when ARB_ROUND_ROBIN_EN is defined.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   ic_req,
  input  logic   dc_req,
  input  logic   grant,
  output logic   any_req,
  output owner_t winner
);

  assign any_req = ic_req | dc_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who was served last; reset to D so I wins the first tie.
  owner_t last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN_DC;
    end else if (grant) begin
      last_q <= winner;
    end
  end

  always_comb begin
    winner = OWN_IC;
    if (ic_req && dc_req) begin
      winner = (last_q == OWN_DC) ? OWN_IC : OWN_DC;
    end else if (dc_req) begin
      winner = OWN_DC;
    end
  end
`else
  logic unused_pick;
  assign unused_pick = ^{clk, rst, grant};

  always_comb begin
    winner = dc_req ? OWN_DC : OWN_IC;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-cache refills and D-cache refills/writebacks.
// Optional macro ARB_ROUND_ROBIN_EN switches tie resolution to round-robin.
//
// Handshake: a requester raises req and holds it (with its fields) until its
// ack pulses for one cycle; rdata is valid in that cycle and held afterwards.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_ack,
  output logic [31:0] ic_rdata,
  input  logic        dc_req,
  input  logic        dc_wr,
  input  logic [31:0] dc_addr,
  input  logic [31:0] dc_wdata,
  output logic        dc_ack,
  output logic [31:0] dc_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output state_t      state_dbg
);

  state_t             state_q, state_d;
  owner_t             owner_q;
  owner_t             winner;
  logic               any_req;
  logic               grant;
  logic               wr_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        ic_rdata_q;
  logic [31:0]        dc_rdata_q;

  assign grant = (state_q == IDLE) && any_req;

  arb_pick u_pick (
    .clk     (clk),
    .rst     (rst),
    .ic_req  (ic_req),
    .dc_req  (dc_req),
    .grant   (grant),
    .any_req (any_req),
    .winner  (winner)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = wr_q ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IC;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      // Fields are captured only at grant so later input changes cannot leak in.
      if (grant) begin
        owner_q <= winner;
        if (winner == OWN_DC) begin
          addr_q  <= dc_addr;
          wr_q    <= dc_wr;
          wdata_q <= dc_wdata;
        end else begin
          addr_q  <= ic_addr;
          wr_q    <= 1'b0;
          wdata_q <= '0;
        end
      end
      if (state_q == ISSUE) begin
        cnt_q <= CNT_W'(MEM_LATENCY - 1);
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == WAIT && cnt_q == '0) begin
        if (owner_q == OWN_IC) ic_rdata_q <= mem_rdata;
        else                   dc_rdata_q <= mem_rdata;
      end
    end
  end

  // Outputs are forced quiet while rst is high, even before the reset edge lands.
  assign mem_en    = !rst && (state_q == ISSUE);
  assign mem_we    = mem_en && wr_q;
  assign mem_addr  = rst ? '0 : addr_q;
  assign mem_wdata = rst ? '0 : wdata_q;
  assign busy      = !rst && (state_q != IDLE);
  assign ic_ack    = !rst && (state_q == RESP) && (owner_q == OWN_IC);
  assign dc_ack    = !rst && (state_q == RESP) && (owner_q == OWN_DC);
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign state_dbg = state_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_LATENCY, default 1: cycles from mem_en to a valid mem_rdata; legal range 1..4.
REQ-002 The block SHALL have port clk  input  1  clock, all logic on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port ic_req  input  1  I-cache refill read request, held until ic_ack.
REQ-005 The block SHALL have port ic_addr  input  32  I-cache word address.
REQ-006 The block SHALL have port ic_ack  output  1  one-cycle pulse; ic_rdata valid in the same cycle.
REQ-007 The block SHALL have port ic_rdata  output  32  I-cache read data.
REQ-008 The block SHALL have port dc_req  input  1  D-cache refill or writeback request, held until dc_ack.
REQ-009 The block SHALL have port dc_wr  input  1  1 = writeback, 0 = refill read.
REQ-010 The block SHALL have port dc_addr  input  32  D-cache word address.
REQ-011 The block SHALL have port dc_wdata  input  32  writeback data.
REQ-012 The block SHALL have port dc_ack  output  1  one-cycle completion pulse.
REQ-013 The block SHALL have port dc_rdata  output  32  D-cache read data, valid with dc_ack.
REQ-014 The block SHALL have port mem_en  output  1  memory access strobe, one cycle per transaction.
REQ-015 The block SHALL have port mem_we  output  1  write enable, qualified by mem_en.
REQ-016 The block SHALL have ports mem_addr  output  32  and mem_wdata  output  32  (memory address and write data).
REQ-017 The block SHALL have port mem_rdata  input  32  memory read data, valid MEM_LATENCY cycles after mem_en.
REQ-018 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL use four states: IDLE, ISSUE, WAIT and RESP.
REQ-020 IDLE SHALL move to ISSUE when any request is pending, latching the winner's owner ID, address, wr flag and wdata.
REQ-021 ISSUE SHALL assert mem_en for exactly one cycle, with mem_we equal to the latched wr and mem_addr/mem_wdata taken from the latches.
REQ-022 For a read, ISSUE SHALL go to WAIT and load the latency counter with MEM_LATENCY-1.
REQ-023 For a write, ISSUE SHALL go directly to RESP.
REQ-024 WAIT SHALL decrement the counter each cycle, sample mem_rdata into the owner's rdata register when the counter reaches 0, and then go to RESP.
REQ-025 RESP SHALL pulse the owner's ack for one cycle and return to IDLE.
- Latency from grant to ack: read = 2+MEM_LATENCY cycles; write = 2 cycles.
REQ-026 Fixed priority SHALL apply: when both requests are pending in IDLE, D-cache wins.
REQ-027 A new grant SHALL NOT be issued in the RESP cycle; the minimum gap between mem_en pulses is 3 cycles for writes.
REQ-028 Latched fields SHALL be immune to input changes after the grant.
REQ-029 A request withdrawn before its ack is a protocol violation; the access SHALL still complete and the ack SHALL still pulse.
REQ-030 ic_rdata and dc_rdata SHALL hold their last value until overwritten by that owner's next read.
REQ-031 mem_en and mem_we SHALL be 0 in every state except ISSUE.

Reset
REQ-032 rst SHALL force IDLE and clear the counter, the latches, both rdata registers and the round-robin pointer.
REQ-033 During rst, ic_ack, dc_ack, mem_en, mem_we and busy SHALL all be 0, and mem_addr/mem_wdata SHALL be 0.
REQ-034 Reset asserted mid-transaction SHALL abort it with no ack; a late mem_rdata SHALL be ignored.

Configuration
REQ-035 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be resolved round-robin.
- A 1-bit last-winner pointer selects the owner not served last; reset value is "last = D", so I-cache wins the first tie.
REQ-036 Without ARB_ROUND_ROBIN_EN, fixed D-over-I priority (REQ-026) SHALL apply and no pointer register SHALL exist.

Structure
REQ-037 Package mem_arb_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT/RESP), the owner encoding (OWN_IC=0, OWN_DC=1) and the MEM_LATENCY range constants.
REQ-038 One sub-module, arb_pick, SHALL hold the combinational winner select, fixed or round-robin under the macro, with pointer update on grant.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- Single I read: MEM_LATENCY=1, ic_req with ic_addr=0x40, memory returns 0xDEADBEEF -> mem_en pulses at cycle 1, ic_ack at cycle 3 with ic_rdata=0xDEADBEEF, dc_ack stays 0.
- D writeback: dc_req=1, dc_wr=1, addr=0x100, wdata=0x12345678 -> one mem_en pulse with mem_we=1 and those values; dc_ack 2 cycles after grant.
- Simultaneous requests, fixed priority: ic_req and dc_req high on the same cycle -> D served first, I granted the cycle after dc_ack; with ARB_ROUND_ROBIN_EN the order is I then D.
- MEM_LATENCY=3 read: ack exactly 5 cycles after grant; busy high for that whole span.
- Reset in WAIT: rst asserted one cycle after mem_en -> no ack ever, busy=0 the next cycle, next request served normally.
- Input change after grant: dc_addr changes 0x10 -> 0x20 during WAIT -> mem_addr stays 0x10.
